game_flow_ctrl: RTL

Parametrised game sequencer that replaces the fixed 2-bit T-flip-flop flow. Adds multi-level progression, a miss limit, a seconds countdown and an optional pause state. Keyboard level inputs (spacebar, esc, pause key) and mole-screen hit/miss pulses drive it. Its screen_sel output drives the VGA screen mux; game_run enables the moles screen.

---
 rtl/game_flow_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: multi-level game sequencer with miss limit, seconds countdown
// and an optional PAUSE state built only when GAME_FLOW_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int TICK_DIV       = 100000000,
    parameter int ROUND_SECS     = 30,
    parameter int NUM_LEVELS     = 3,
    parameter int HITS_PER_LEVEL = 10,
    parameter int MAX_MISSES     = 3,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               key_start,
    input  logic               key_pause,
    input  logic               key_abort,
    input  logic               hit_pulse,
    input  logic               miss_pulse,
    output logic [2:0]         screen_sel,
    output logic               game_run,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic [7:0]         secs_left,
    output logic               timer_done
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_LVLUP = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         level_q, level_d, misses_q, misses_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         hits_q, hits_d, secs_q, secs_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               timer_done_q, timer_done_d;
    logic               prev_start_q, rise_start, tc;

    assign rise_start = key_start & ~prev_start_q;
    assign tc         = presc_q == PW'(TICK_DIV - 1);

`ifdef GAME_FLOW_PAUSE_EN
    logic prev_pause_q, rise_pause;
    assign rise_pause = key_pause & ~prev_pause_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_pause_q <= 1'b1;
        else          prev_pause_q <= key_pause;
    end
`else
    logic unused_pause;
    assign unused_pause = key_pause;
`endif

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hits_d       = hits_q;
        secs_d       = secs_q;
        presc_d      = presc_q;
        timer_done_d = 1'b0;
        if (key_abort) begin
            state_d = S_START;
        end else begin
            case (state_q)
                S_START: if (rise_start) state_d = S_PLAY;
                S_PLAY: begin
                    presc_d = tc ? '0 : presc_q + 1'b1;
                    if (tc) secs_d = secs_q - 8'd1;
                    if (hit_pulse) begin
                        score_d = &score_q ? score_q : score_q + 1'b1;
                        hits_d  = hits_q + 8'd1;
                    end
                    if (miss_pulse) misses_d = misses_q + 4'd1;
                    // Exits judged on post-update counts; miss limit outranks level clear
                    if (misses_d == 4'(MAX_MISSES)) begin
                        state_d = S_LOSE;
                    end else if (hits_d == 8'(HITS_PER_LEVEL)) begin
                        state_d = (level_q == 4'(NUM_LEVELS - 1)) ? S_WIN : S_LVLUP;
                    end else if (tc && secs_q == 8'd1) begin
                        state_d      = S_LOSE;
                        timer_done_d = 1'b1;
                    end
`ifdef GAME_FLOW_PAUSE_EN
                    else if (rise_pause) begin
                        state_d = S_PAUSE;
                    end
`endif
                end
`ifdef GAME_FLOW_PAUSE_EN
                S_PAUSE: if (rise_pause) state_d = S_PLAY;
`endif
                S_LVLUP: begin
                    if (rise_start) begin
                        state_d = S_PLAY;
                        level_d = level_q + 4'd1;
                        hits_d  = '0;
                        secs_d  = 8'(ROUND_SECS);
                        presc_d = '0;
                    end
                end
                S_WIN, S_LOSE: if (rise_start) state_d = S_START;
                default: state_d = S_START;
            endcase
        end
        // Abort and a fresh game start share the same counter initialisation
        if (key_abort || (state_q == S_START && rise_start)) begin
            level_d  = '0;
            score_d  = '0;
            misses_d = '0;
            hits_d   = '0;
            presc_d  = '0;
            secs_d   = 8'(ROUND_SECS);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_START;
            level_q      <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            hits_q       <= '0;
            secs_q       <= 8'(ROUND_SECS);
            presc_q      <= '0;
            timer_done_q <= 1'b0;
            prev_start_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hits_q       <= hits_d;
            secs_q       <= secs_d;
            presc_q      <= presc_d;
            timer_done_q <= timer_done_d;
            prev_start_q <= key_start;
        end
    end

    assign screen_sel = state_q;
    assign game_run   = state_q == S_PLAY;
    assign level      = level_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign secs_left  = secs_q;
    assign timer_done = timer_done_q;
endmodule
